// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the combinational ROM and
// registers {pc, instr} into the IF/ID slot with valid/ready.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_LIMIT = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [31:0]      pc_out,
  input  logic [31:0]      instr_in,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] fetch_count,
  output logic             wrap_pulse
);

  localparam logic [31:0] LIMIT = 32'(PC_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0] pc_reg;
  logic [31:0] pc_inc;
  logic [31:0] next_pc;
  logic [31:0] redir_pc;
  logic        wraps;
  logic        xfer;
  logic        load;
  logic        do_redir;
  logic        do_load;
  logic        do_drain;

  assign pc_out   = pc_reg;
  assign pc_inc   = pc_reg + 32'd4;
  assign wraps    = pc_inc >= LIMIT;
  assign next_pc  = wraps ? RESET_PC : pc_inc;
  assign redir_pc = redirect_target & ~32'd3;

  assign xfer = out_valid & out_ready;
  assign load = enable & (~out_valid | out_ready);

  // Mutually exclusive decode of the priority chain
  assign do_redir = redirect_valid;
  assign do_load  = load & ~redirect_valid;
  assign do_drain = xfer & ~load & ~redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      out_valid   <= 1'b0;
      out_pc      <= 32'd0;
      out_instr   <= 32'd0;
      fetch_count <= '0;
      wrap_pulse  <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      unique case (1'b1)
        do_redir: begin
          pc_reg    <= redir_pc;
          out_valid <= 1'b0;
        end
        do_load: begin
          out_pc     <= pc_reg;
          out_instr  <= instr_in;
          out_valid  <= 1'b1;
          pc_reg     <= next_pc;
          wrap_pulse <= wraps;
          if (fetch_count != CNT_MAX)
            fetch_count <= fetch_count + CNT_W'(1);
        end
        do_drain: begin
          out_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal
// expectations plus a randomized run against a cycle model.
module tb_instruction_fetch;

  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          redirect_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   redirect_target = 32'd0;
  logic [31:0]   pc_out;
  logic [31:0]   instr_in;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_valid;
  logic          wrap_pulse;
  logic [CW-1:0] fetch_count;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_opc = 32'd0;
  logic [31:0] m_oinstr = 32'd0;
  logic        m_valid = 1'b0;
  logic        m_wrap = 1'b0;
  int          m_cnt = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a < 32'd16)
      return 32'h0004_1800 + {14'd0, a[3:2], 16'd0};
    return 32'd0;
  endfunction

  assign instr_in = rom(pc_out);

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .PC_LIMIT (32),
    .CNT_W    (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .pc_out          (pc_out),
    .instr_in        (instr_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .fetch_count     (fetch_count),
    .wrap_pulse      (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference: one fetch decision per clock from the stage rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc     <= 32'd0;
      m_opc    <= 32'd0;
      m_oinstr <= 32'd0;
      m_valid  <= 1'b0;
      m_wrap   <= 1'b0;
      m_cnt    <= 0;
    end else begin
      m_wrap <= 1'b0;
      if (redirect_valid) begin
        m_pc    <= redirect_target & ~32'd3;
        m_valid <= 1'b0;
      end else if (enable && (!m_valid || out_ready)) begin
        m_opc    <= m_pc;
        m_oinstr <= rom(m_pc);
        m_valid  <= 1'b1;
        m_cnt    <= (m_cnt == CMAX) ? m_cnt : m_cnt + 1;
        if (m_pc + 32'd4 >= 32'd32) begin
          m_pc   <= 32'd0;
          m_wrap <= 1'b1;
        end else begin
          m_pc <= m_pc + 32'd4;
        end
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_out", pc_out, m_pc);
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_pc", out_pc, m_opc);
      chk("out_instr", out_instr, m_oinstr);
      chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
      chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
      if (out_valid)
        chk("rom_pair", out_instr, rom(out_pc));
    end
  end

  // Assert reset off the clock edges, check it took effect at once
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);
    chk("rst_wrap", 32'(wrap_pulse), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;

    // Free-running stream with wrap
    do_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_out_pc", out_pc, 32'((i * 4) % 32));
      chk("t1_instr", out_instr,
          ((i % 8) < 4) ? 32'h0004_1800 + 32'((i % 8) * 32'h1_0000)
                        : 32'd0);
      chk("t1_wrap", 32'(wrap_pulse), 32'(i == 7));
    end

    // Back-pressure
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_out_pc", out_pc, 32'd0);
      chk("t2_instr", out_instr, 32'h0004_1800);
      chk("t2_pc_out", pc_out, 32'd4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_resume4", out_pc, 32'd4);
    @(negedge clk);
    chk("t2_resume8", out_pc, 32'd8);

    // Redirect with misaligned target
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_000B;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t3_flush", 32'(out_valid), 32'd0);
    chk("t3_pc_out", pc_out, 32'd8);
    @(negedge clk);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_out_pc", out_pc, 32'd8);
    chk("t3_instr", out_instr, 32'h0006_1800);

    // Redirect coinciding with a transfer
    do_reset();
    @(negedge clk);
    @(negedge clk);
    chk("t4_cnt_pre", 32'(fetch_count), 32'd2);
    chk("t4_pc_pre", out_pc, 32'd4);
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0010;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t4_cnt_same", 32'(fetch_count), 32'd2);
    chk("t4_flush", 32'(out_valid), 32'd0);
    chk("t4_pc_out", pc_out, 32'h10);
    @(negedge clk);
    chk("t4_out_pc", out_pc, 32'h10);
    chk("t4_cnt", 32'(fetch_count), 32'd3);

    // enable low drains one and freezes the PC
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_pc_out", pc_out, 32'h14);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("t5_resume", out_pc, 32'h14);
    chk("t5_rvalid", 32'(out_valid), 32'd1);

    // Mid-stream async reset
    @(negedge clk);
    @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("t6_valid", 32'(out_valid), 32'd1);
    chk("t6_out_pc", out_pc, 32'd0);

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: redirect_target = $urandom;
        1: redirect_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: redirect_target = 32'($urandom_range(0, 47));
      endcase
      if (!rst_n)
        #2 rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0)
        #2 rst_n = 1'b0;
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
